// File: rtl/sprite_renderer_if.sv
// Sprite ROM read bus: the renderer drives the address and the ROM returns the
// addressed word one clock later.
interface sprite_renderer_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 16
);
  logic [ADDR_WIDTH-1:0] rom_addr;
  logic [DATA_WIDTH-1:0] rom_data;

  modport master (output rom_addr, input rom_data);
  modport slave  (input rom_addr, output rom_data);
endinterface

// File: rtl/sprite_renderer.sv
// Sprite pixel pipeline: box test and ROM address generation from the VGA
// counters, then a colour-key transparency test on the returned ROM word.
// Latency from hcount/vcount to pixel_out/sprite_hit is 3 clocks.
module sprite_renderer #(
  parameter int                    SPRITE_W    = 32,
  parameter int                    SPRITE_H    = 32,
  parameter int                    NUM_FRAMES  = 4,
  parameter int                    ADDR_WIDTH  = 12,
  parameter int                    DATA_WIDTH  = 16,
  parameter logic [DATA_WIDTH-1:0] TRANSPARENT = 16'hF81F,
  parameter int                    ANIM_DIV    = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [9:0]                    hcount,
  input  logic [9:0]                    vcount,
  input  logic                          video_on,
  input  logic                          frame_start,
  input  logic [9:0]                    pos_x,
  input  logic [9:0]                    pos_y,
  input  logic                          flip_h,
  input  logic                          anim_en,
  sprite_renderer_if.master             rom,
  output logic [DATA_WIDTH-1:0]         pixel_out,
  output logic                          sprite_hit,
  output logic [$clog2(NUM_FRAMES)-1:0] frame_idx
);

  localparam int XW = $clog2(SPRITE_W);
  localparam int YW = $clog2(SPRITE_H);
  localparam int FW = $clog2(NUM_FRAMES);
  localparam int DW = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(ANIM_DIV - 1);

  logic [9:0]    r_lx;
  logic [9:0]    r_ly;
  logic          r_lflip;
  logic [DW-1:0] r_div;
  logic          r_s1;
  logic          r_s2;

  logic [10:0]   w_x_end;
  logic [10:0]   w_y_end;
  logic          w_in_box;
  logic [XW-1:0] w_rel_x;
  logic [YW-1:0] w_rel_y;
  logic [XW-1:0] w_col;
  logic          w_opaque;

  // Per-frame state: position/flip latch and animation stepping on frame_start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lx      <= '0;
      r_ly      <= '0;
      r_lflip   <= 1'b0;
      r_div     <= '0;
      frame_idx <= '0;
    end else if (frame_start) begin
      r_lx    <= pos_x;
      r_ly    <= pos_y;
      r_lflip <= flip_h;
      if (anim_en) begin
        if (r_div == DIV_LAST) begin
          r_div     <= '0;
          frame_idx <= frame_idx + FW'(1);
        end else begin
          r_div <= r_div + DW'(1);
        end
      end
    end
  end

  // Box test and sprite-relative coordinates; right/bottom edges use 11-bit
  // sums so a sprite near column 1023 never wraps into column 0.
  always_comb begin
    w_x_end  = {1'b0, r_lx} + 11'(SPRITE_W);
    w_y_end  = {1'b0, r_ly} + 11'(SPRITE_H);
    w_in_box = video_on
               && (hcount >= r_lx) && ({1'b0, hcount} < w_x_end)
               && (vcount >= r_ly) && ({1'b0, vcount} < w_y_end);
    // Only the low bits of the difference are needed, and they depend only on
    // the low bits of the operands; SPRITE_W-1-rel_x reduces to ~rel_x there.
    w_rel_x  = hcount[XW-1:0] - r_lx[XW-1:0];
    w_rel_y  = vcount[YW-1:0] - r_ly[YW-1:0];
    w_col    = r_lflip ? ~w_rel_x : w_rel_x;
    w_opaque = r_s2 && (rom.rom_data != TRANSPARENT);
  end

  // Registered ROM address; zero outside the sprite box.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rom.rom_addr <= '0;
    end else if (w_in_box) begin
      rom.rom_addr <= {frame_idx, w_rel_y, w_col};
    end else begin
      rom.rom_addr <= '0;
    end
  end

  // In-box delay line aligned with ROM data, then the colour-key output stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1       <= 1'b0;
      r_s2       <= 1'b0;
      sprite_hit <= 1'b0;
      pixel_out  <= '0;
    end else begin
      r_s1       <= w_in_box;
      r_s2       <= r_s1;
      sprite_hit <= w_opaque;
      pixel_out  <= w_opaque ? rom.rom_data : '0;
    end
  end

endmodule

// File: doc/sprite_renderer.md
Name: sprite_renderer

Overview:
- Pixel-pipeline stage directly upstream of the sprite ROM. It takes the VGA timing counters and a sprite position and generates the ROM read address.
- It consumes the ROM word returned one clock later and emits a per-pixel colour with a hit/transparency flag to the downstream colour mux.
- It supports multi-frame walk animation stored as consecutive 32x32 images in one ROM, plus horizontal flip.

Parameters:
- SPRITE_W, 32, sprite width in pixels (power of two).
- SPRITE_H, 32, sprite height in pixels (power of two).
- NUM_FRAMES, 4, animation frames stored back-to-back in ROM (power of two).
- ADDR_WIDTH, 12, ROM address width; must equal log2(SPRITE_W*SPRITE_H*NUM_FRAMES).
- DATA_WIDTH, 16, ROM word / pixel width (RGB565).
- TRANSPARENT, 16'hF81F, colour key treated as see-through.
- ANIM_DIV, 8, frame_start pulses per animation step.

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- hcount  input  10  current pixel column from VGA timing.
- vcount  input  10  current pixel row from VGA timing.
- video_on  input  1  visible-area flag aligned with hcount/vcount.
- frame_start  input  1  one-cycle pulse at start of vertical blank.
- pos_x  input  10  requested sprite left edge.
- pos_y  input  10  requested sprite top edge.
- flip_h  input  1  requested horizontal mirror.
- anim_en  input  1  animation advance enable.
- rom_addr  output  ADDR_WIDTH  registered address to sprite ROM.
- rom_data  input  DATA_WIDTH  ROM data_out (valid one clock after rom_addr).
- pixel_out  output  DATA_WIDTH  sprite colour; 0 when sprite_hit=0.
- sprite_hit  output  1  sprite covers this pixel and is opaque.
- frame_idx  output  log2(NUM_FRAMES)  current animation frame.

Behaviour:
- Reset (async, rst_n=0):
  - rom_addr=0, pixel_out=0, sprite_hit=0, frame_idx=0.
  - Latched position = (0,0), latched flip=0, anim divider=0, pipeline valid bits=0.
- Position latch:
  - pos_x, pos_y and flip_h are captured only on the clock where frame_start=1.
  - The whole frame renders with a consistent position; mid-frame input changes are ignored.
- Animation:
  - On frame_start with anim_en=1, the divider increments.
  - When the divider reaches ANIM_DIV-1, it clears and frame_idx increments, wrapping NUM_FRAMES-1 -> 0.
  - With anim_en=0, divider and frame_idx hold.
  - frame_idx changes on the same edge as the position latch, so both take effect from the same frame.
- Box test (cycle t, combinational):
  - in_box = video_on AND hcount >= lx AND hcount < lx+SPRITE_W AND vcount >= ly AND vcount < ly+SPRITE_H.
  - Sums use 11 bits so positions near 1023 do not wrap into column 0.
- Address (registered, valid at t+1):
  - rel_x = hcount-lx, rel_y = vcount-ly.
  - col = lflip ? SPRITE_W-1-rel_x : rel_x.
  - rom_addr = {frame_idx, rel_y[log2 H-1:0], col[log2 W-1:0]} when in_box, else 0.
- Pipeline:
  - in_box is delayed two stages (s1 at t+1, s2 at t+2) to align with rom_data valid at t+2.
  - At the t+2 -> t+3 edge: sprite_hit <= s2 AND (rom_data != TRANSPARENT); pixel_out <= sprite_hit-next ? rom_data : 0.
  - Total latency hcount -> pixel_out/sprite_hit = 3 clocks. The downstream mux delays its background path by 3 to match.
- Pipeline runs every clock; there is no stall or handshake.
- Reset mid-line: outputs go to 0 immediately; the first valid hit appears 3 clocks after the first in_box cycle following release.
- frame_start coinciding with a visible pixel (not expected): that pixel uses the old position; the next pixel uses the new one.

Test Plan:
1. Reset -> pos (100,50) latched via frame_start; scan hcount 99..132 at vcount 50 -> rom_addr=0 for hcount 99; rom_addr 0..31 for hcount 100..131; 0 for 132. sprite_hit is high 3 clocks after each in-box pixel whose data != 16'hF81F.
2. ROM model returns 16'hF81F at addr 5, 16'h07E0 elsewhere -> pixel at hcount 105 gives sprite_hit=0, pixel_out=0; hcount 106 gives pixel_out=16'h07E0.
3. flip_h=1, pos (0,0), vcount 1, hcount 0 -> rom_addr=12'd63; hcount 31 -> rom_addr=12'd32.
4. anim_en=1, 8 frame_start pulses -> frame_idx 0->1. After 32 pulses -> wraps to 0. Addresses for frame 2 carry 12'h800 offset.
5. pos_x=1010, hcount 1010..1023 -> in_box high, no hit at hcount 0..9 (no wrap). pos_x changed mid-frame without frame_start -> render unchanged.
6. Assert rst_n=0 during active sprite row -> outputs 0 asynchronously. After release, the first hit appears exactly 3 clocks after the next in-box pixel.
